keypad_scanner: RTL and testbench

Scans a 4x4 active-low matrix keypad and reports each debounced keypress as a hex code, plus the last two digits entered. It is the input counterpart of the time-multiplexed seven-segment path. Columns are driven one at a time, and rows are read back through a synchronizer. `digit_new`/`digit_old` feed the display muxer's two 4-bit inputs directly, so the display shows the two most recent keys.

---
 rtl/keypad_scanner.sv | 197 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad one column at a time,
// debounces press and release of a single key, and reports each accepted key
// as a hex code together with a two-deep digit history for the display muxer.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_EXP        = 14,
  parameter int DEBOUNCE_CYCLES = 240000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_DONE   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [SCAN_EXP-1:0] DWELL_LAST = {SCAN_EXP{1'b1}};

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_t;

  state_t              state_r;
  logic [3:0]          rows_meta_r;
  logic [3:0]          rs_r;
  logic [1:0]          col_idx_r;
  logic [1:0]          row_idx_r;
  logic [SCAN_EXP-1:0] dwell_r;
  logic [CNT_W-1:0]    db_cnt_r;

  logic                rs_row_s;
  logic                dwell_last_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [1:0]          col_next_s;
  logic [3:0]          code_s;

  // Active-low drive pattern for a column index.
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // True when exactly one synchronized row line is pulled low.
  function automatic logic one_low(input logic [3:0] r);
    case (r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // Index of the single low row line (only meaningful when one_low holds).
  function automatic logic [1:0] low_index(input logic [3:0] r);
    case (r)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Keypad legend lookup, row-major.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:  return 4'h1;
      4'd1:  return 4'h2;
      4'd2:  return 4'h3;
      4'd3:  return 4'hA;
      4'd4:  return 4'h4;
      4'd5:  return 4'h5;
      4'd6:  return 4'h6;
      4'd7:  return 4'hB;
      4'd8:  return 4'h7;
      4'd9:  return 4'h8;
      4'd10: return 4'h9;
      4'd11: return 4'hC;
      4'd12: return 4'hE;
      4'd13: return 4'h0;
      4'd14: return 4'hF;
      4'd15: return 4'hD;
      default: return 4'h0;
    endcase
  endfunction

  // Decode helpers: captured row level, end of dwell, saturating count step.
  always_comb begin
    rs_row_s     = rs_r[row_idx_r];
    dwell_last_s = (dwell_r == DWELL_LAST);
    col_next_s   = col_idx_r + 2'd1;
    code_s       = key_map(row_idx_r, col_idx_r);
    if (db_cnt_r == CNT_MAX) begin
      cnt_inc_s = db_cnt_r;
    end else begin
      cnt_inc_s = db_cnt_r + CNT_W'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_r <= 4'b1111;
      rs_r        <= 4'b1111;
    end else begin
      rows_meta_r <= rows;
      rs_r        <= rows_meta_r;
    end
  end

  // Scan/debounce state machine with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= SCAN;
      col_idx_r <= 2'd0;
      row_idx_r <= 2'd0;
      dwell_r   <= '0;
      db_cnt_r  <= '0;
      cols      <= 4'b1110;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      digit_new <= 4'h0;
      digit_old <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      case (state_r)
        SCAN: begin
          dwell_r <= dwell_r + SCAN_EXP'(1);
          if (dwell_last_s) begin
            if (one_low(rs_r)) begin
              // Column stays frozen so the captured key remains driven.
              row_idx_r <= low_index(rs_r);
              db_cnt_r  <= '0;
              state_r   <= DB_PRESS;
            end else begin
              col_idx_r <= col_next_s;
              cols      <= col_drive(col_next_s);
            end
          end
        end
        DB_PRESS: begin
          if (!rs_row_s) begin
            if (cnt_inc_s == CNT_DONE) begin
              key_valid <= 1'b1;
              key_code  <= code_s;
              digit_old <= digit_new;
              digit_new <= code_s;
              db_cnt_r  <= '0;
              state_r   <= HELD;
            end else begin
              db_cnt_r <= cnt_inc_s;
            end
          end else begin
            // Press did not hold: abandon it and resume on the next column.
            state_r   <= SCAN;
            dwell_r   <= '0;
            col_idx_r <= col_next_s;
            cols      <= col_drive(col_next_s);
          end
        end
        HELD: begin
          if (rs_row_s) begin
            db_cnt_r <= '0;
            state_r  <= DB_REL;
          end else begin
            state_r <= HELD;
          end
        end
        DB_REL: begin
          if (rs_row_s) begin
            if (cnt_inc_s == CNT_DONE) begin
              db_cnt_r  <= '0;
              state_r   <= SCAN;
              dwell_r   <= '0;
              col_idx_r <= col_next_s;
              cols      <= col_drive(col_next_s);
            end else begin
              db_cnt_r <= cnt_inc_s;
            end
          end else begin
            // Release bounce: key is still down, no new report.
            state_r <= HELD;
          end
        end
        default: begin
          state_r <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SE = 2;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  // pressed[r*4+c] models key at row r, column c being held down
  logic [15:0] pressed = 16'h0000;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic [3:0]  scan_tbl[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0]  prev_cols;
  int          trans;

  always #5 clk = ~clk;

  // keypad matrix: a row reads low when a pressed key sits on a driven column
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      rows[r] = ~|(pressed[r*4 +: 4] & ~cols);
    end
  end

  keypad_scanner #(.SCAN_EXP(SE), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .key_code(key_code),
    .key_valid(key_valid),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] code, input logic [3:0] dn, input logic [3:0] dold);
    exp_q.push_back({code, dn, dold});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cols(input logic [3:0] target, input string name);
    int k;
    k = 0;
    while (cols !== target && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk(name, {28'd0, cols}, {28'd0, target});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // monitor: every key_valid pulse is matched against the scoreboard head
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: got code %0h, expected no pulse", key_code);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse code/new/old", {20'd0, key_code, digit_new, digit_old}, {20'd0, mon_e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(6);

    // 1: reset mid-scan, then free-running scan
    #2 reset = 1'b1;
    #1 chk("t1_reset_state", {15'd0, cols, key_valid, key_code, digit_new, digit_old},
           {15'd0, 4'b1110, 1'b0, 12'h000});
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("t1_scan_step", {28'd0, cols}, {28'd0, scan_tbl[(k / 4) % 4]});
    end

    // 2: key 6 (row 1, col 2) held 40 cycles, then release timing
    pressed[1*4+2] = 1'b1;
    push(4'h6, 4'h6, 4'h0);
    cycles(40);
    chk("t2_held_cols", {28'd0, cols}, {28'd0, 4'b1011});
    chk("t2_pulse_seen", exp_q.size(), 0);
    pressed = 16'h0000;
    cycles(10);
    chk("t2_rel_cols_hold", {28'd0, cols}, {28'd0, 4'b1011});
    cycles(1);
    chk("t2_rel_cols_next", {28'd0, cols}, {28'd0, 4'b0111});

    // 3: bouncing press of key 0 (row 3, col 1)
    wait_cols(4'b1101, "t3_reach_col1");
    pressed[3*4+1] = 1'b1; cycles(1);
    pressed[3*4+1] = 1'b0; cycles(1);
    pressed[3*4+1] = 1'b1; cycles(1);
    pressed[3*4+1] = 1'b0; cycles(1);
    pressed[3*4+1] = 1'b1;
    push(4'h0, 4'h0, 4'h6);
    wait_drain("t3_pulse", 40);
    pressed = 16'h0000;
    cycles(30);

    // 4: 7 then C
    pressed[2*4+0] = 1'b1;
    push(4'h7, 4'h7, 4'h0);
    wait_drain("t4_pulse7", 40);
    pressed = 16'h0000;
    cycles(30);
    pressed[2*4+3] = 1'b1;
    push(4'hC, 4'hC, 4'h7);
    wait_drain("t4_pulseC", 40);
    chk("t4_digits", {24'd0, digit_new, digit_old}, {24'd0, 8'hC7});
    pressed = 16'h0000;
    cycles(30);

    // 5: two rows low on column 0 -> keeps scanning
    pressed[0*4+0] = 1'b1;
    pressed[2*4+0] = 1'b1;
    prev_cols = cols;
    trans = 0;
    repeat (24) begin
      @(negedge clk);
      if (cols !== prev_cols) trans++;
      prev_cols = cols;
    end
    chk("t5_scan_transitions", trans, 6);
    // single key 1, then a short release glitch
    pressed = 16'h0001;
    push(4'h1, 4'h1, 4'hC);
    wait_drain("t5_pulse", 40);
    chk("t5_held_cols", {28'd0, cols}, {28'd0, 4'b1110});
    pressed = 16'h0000;
    cycles(3);
    pressed = 16'h0001;
    cycles(20);
    chk("t5_glitch_cols", {28'd0, cols}, {28'd0, 4'b1110});
    pressed = 16'h0000;
    cycles(30);
    chk("t5_no_extra", exp_q.size(), 0);

    // 6: reset while HELD on key 5 (row 1, col 1)
    pressed[1*4+1] = 1'b1;
    push(4'h5, 4'h5, 4'h1);
    wait_drain("t6_pulse", 40);
    cycles(2);
    #2 reset = 1'b1;
    #1 chk("t6_reset_state", {15'd0, cols, key_valid, key_code, digit_new, digit_old},
           {15'd0, 4'b1110, 1'b0, 12'h000});
    @(negedge clk);
    reset = 1'b0;
    push(4'h5, 4'h5, 4'h0);
    repeat (15) @(negedge clk);
    chk("t6_latency_pre", {31'd0, key_valid}, 32'd0);
    @(negedge clk);
    chk("t6_latency_edge", {31'd0, key_valid}, 32'd1);
    wait_drain("t6_pulse2", 4);
    pressed = 16'h0000;
    cycles(30);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
